// File: rtl/l2h_pkg.sv
// Shared types and helpers for the low-to-high width stream converter.
// Frame parser states and header sizing.
package l2h_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        LEN,
        DATA
    } state_t;

    localparam logic [7:0] CMD_WRITE_DEFAULT = 8'hA5;

    function automatic int addr_words(input int addr_width, input int low_width);
        return (addr_width + low_width - 1) / low_width;
    endfunction

endpackage

// File: rtl/low_to_high_stream_if.sv
// Low-side word stream and high-side beat bus of the converter.
// The converter uses the slave view, the traffic source/sink the master view.
interface low_to_high_stream_if #(
    parameter int LOW_DATA_WIDTH = 8,
    parameter int ADDR_WIDTH     = 16,
    parameter int RATIO          = 4
);
    localparam int HIGH_DATA_WIDTH = LOW_DATA_WIDTH * RATIO;

    logic                       low_read_valid;
    logic                       low_read_ready;
    logic [LOW_DATA_WIDTH-1:0]  low_read_data;

    logic                       high_write_valid;
    logic                       high_write_ready;
    logic [ADDR_WIDTH-1:0]      high_write_addr;
    logic [HIGH_DATA_WIDTH-1:0] high_write_data;
    logic [RATIO-1:0]           high_write_strb;
    logic                       high_write_last;

    modport slave (
        input  low_read_valid,
        input  low_read_data,
        output low_read_ready,
        output high_write_valid,
        input  high_write_ready,
        output high_write_addr,
        output high_write_data,
        output high_write_strb,
        output high_write_last
    );

    modport master (
        output low_read_valid,
        output low_read_data,
        input  low_read_ready,
        input  high_write_valid,
        output high_write_ready,
        input  high_write_addr,
        input  high_write_data,
        input  high_write_strb,
        input  high_write_last
    );

endinterface

// File: rtl/l2h_out_reg.sv
// Single-entry valid/ready holding register for one high-side beat.
// can_load is high when a new beat may be written this cycle without loss.
module l2h_out_reg #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] next_addr,
    input  logic [DATA_WIDTH-1:0] next_data,
    input  logic [STRB_WIDTH-1:0] next_strb,
    input  logic                  next_last,
    input  logic                  sink_ready,
    output logic                  valid,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data,
    output logic [STRB_WIDTH-1:0] strb,
    output logic                  last,
    output logic                  can_load
);

    assign can_load = !valid || sink_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
            strb  <= '0;
            last  <= 1'b0;
        end else if (load && can_load) begin
            valid <= 1'b1;
            addr  <= next_addr;
            data  <= next_data;
            strb  <= next_strb;
            last  <= next_last;
        end else if (sink_ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/low_to_high_stream.sv
// Parses command/address/length framed low words and packs the payload
// into wide beats with incrementing addresses, strobes and a last flag.
module low_to_high_stream
    import l2h_pkg::*;
#(
    parameter int                        LOW_DATA_WIDTH = 8,
    parameter int                        ADDR_WIDTH     = 16,
    parameter int                        BRUST_SIZE_LOG = 2,
    parameter logic [LOW_DATA_WIDTH-1:0] CMD_WRITE      = LOW_DATA_WIDTH'(CMD_WRITE_DEFAULT),
    parameter int                        LEN_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    low_to_high_stream_if.slave       bus,
    output logic                      busy,
    output logic [7:0]                drop_count
);

    localparam int RATIO           = 1 << BRUST_SIZE_LOG;
    localparam int HIGH_DATA_WIDTH = LOW_DATA_WIDTH * RATIO;
    localparam int ADDR_WORDS      = addr_words(ADDR_WIDTH, LOW_DATA_WIDTH);
    localparam int AIW             = (ADDR_WORDS > 1) ? $clog2(ADDR_WORDS) : 1;
    localparam int AWIDE           = ADDR_WORDS * LOW_DATA_WIDTH;

    state_t                     state;
    state_t                     state_nxt;
    logic                       accept;
    logic [AIW-1:0]             addr_idx;
    logic [AWIDE-1:0]           addr_wide;
    logic [AWIDE-1:0]           addr_next;
    logic [ADDR_WIDTH-1:0]      beat_addr;
    logic [LEN_WIDTH-1:0]       len;
    logic [LEN_WIDTH-1:0]       k;
    logic [LEN_WIDTH-1:0]       len_word;
    logic [BRUST_SIZE_LOG-1:0]  lane;
    logic [HIGH_DATA_WIDTH-1:0] buf_data;
    logic [RATIO-1:0]           buf_strb;
    logic [HIGH_DATA_WIDTH-1:0] beat_data;
    logic [RATIO-1:0]           beat_strb;
    logic                       cmd_hit;
    logic                       addr_last;
    logic                       last_word;
    logic                       completes;
    logic                       can_load;

    assign accept    = bus.low_read_valid && bus.low_read_ready;
    assign cmd_hit   = bus.low_read_data == CMD_WRITE;
    assign addr_last = addr_idx == AIW'(ADDR_WORDS - 1);
    assign len_word  = bus.low_read_data[LEN_WIDTH-1:0];
    assign lane      = k[BRUST_SIZE_LOG-1:0];
    assign last_word = k == len - LEN_WIDTH'(1);
    assign completes = (state == DATA)
                     && ((lane == {BRUST_SIZE_LOG{1'b1}}) || last_word);

    assign beat_data = buf_data
                     | (HIGH_DATA_WIDTH'(bus.low_read_data) << (lane * LOW_DATA_WIDTH));
    assign beat_strb = buf_strb | (RATIO'(1) << lane);

    always_comb begin
        addr_next = addr_wide;
        addr_next[addr_idx*LOW_DATA_WIDTH +: LOW_DATA_WIDTH] = bus.low_read_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            unique case (state)
                IDLE: if (cmd_hit) state_nxt = ADDR;
                ADDR: if (addr_last) state_nxt = LEN;
                LEN:  state_nxt = (len_word == '0) ? IDLE : DATA;
                DATA: if (last_word) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Stall a low word only if it would complete a beat that cannot be stored.
    always_comb begin
        bus.low_read_ready = rst_n && ((state != DATA) || !completes || can_load);
        busy               = (state != IDLE) || bus.high_write_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
            addr_idx   <= '0;
            addr_wide  <= '0;
            beat_addr  <= '0;
            len        <= '0;
            k          <= '0;
            buf_data   <= '0;
            buf_strb   <= '0;
        end else if (accept) begin
            unique case (state)
                IDLE: begin
                    if (!cmd_hit && drop_count != 8'hFF)
                        drop_count <= drop_count + 8'd1;
                    addr_idx <= '0;
                end
                ADDR: begin
                    addr_wide <= addr_next;
                    addr_idx  <= addr_last ? '0 : addr_idx + AIW'(1);
                    if (addr_last) beat_addr <= addr_next[ADDR_WIDTH-1:0];
                end
                LEN: begin
                    len      <= len_word;
                    k        <= '0;
                    buf_data <= '0;
                    buf_strb <= '0;
                end
                DATA: begin
                    k <= k + LEN_WIDTH'(1);
                    if (completes) begin
                        buf_data  <= '0;
                        buf_strb  <= '0;
                        beat_addr <= beat_addr + ADDR_WIDTH'(1);
                    end else begin
                        buf_data <= beat_data;
                        buf_strb <= beat_strb;
                    end
                end
                default: ;
            endcase
        end
    end

    l2h_out_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (HIGH_DATA_WIDTH),
        .STRB_WIDTH (RATIO)
    ) u_out_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept && completes),
        .next_addr  (beat_addr),
        .next_data  (beat_data),
        .next_strb  (beat_strb),
        .next_last  (last_word),
        .sink_ready (bus.high_write_ready),
        .valid      (bus.high_write_valid),
        .addr       (bus.high_write_addr),
        .data       (bus.high_write_data),
        .strb       (bus.high_write_strb),
        .last       (bus.high_write_last),
        .can_load   (can_load)
    );

endmodule

// File: doc/low_to_high_stream.md
Name: low_to_high_stream

Overview:
- Parametrised successor to the low-width-to-high-width frame converter.
- Parses framed low-width words (command, N-word address, length, payload) and packs the payload into high-width beats with incrementing addresses.
- Adds valid/ready backpressure on both sides, byte-lane strobes for a partial final beat, a last flag, and a drop counter for non-command words.
- Sits between a narrow serial-style bus receiver and the wide memory write bus.

Parameters:
- LOW_DATA_WIDTH, 8, width of one low-side word.
- ADDR_WIDTH, 16, high-side address width.
- BRUST_SIZE_LOG, 2, log2 of low words per high beat (RATIO = 2**BRUST_SIZE_LOG, HIGH_DATA_WIDTH = LOW_DATA_WIDTH*RATIO).
- CMD_WRITE, 8'hA5, command word that opens a frame.
- LEN_WIDTH, 8, width of the length field; must be <= LOW_DATA_WIDTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- low_read_valid  in  1  low word present.
- low_read_ready  out  1  block accepts low word this cycle.
- low_read_data  in  LOW_DATA_WIDTH  low word.
- high_write_valid  out  1  beat present.
- high_write_ready  in  1  sink accepts beat.
- high_write_addr  out  ADDR_WIDTH  beat address.
- high_write_data  out  HIGH_DATA_WIDTH  beat data.
- high_write_strb  out  RATIO  per-lane valid mask.
- high_write_last  out  1  final beat of frame.
- busy  out  1  state != IDLE or output beat pending.
- drop_count  out  8  saturating count of words discarded in IDLE.

Behaviour:
- Accept = low_read_valid && low_read_ready. All state advances only on accept.
- Reset values:
  - All outputs 0; drop_count 0; state IDLE.
  - Address, length and counter registers 0.
- ADDR_WORDS = ceil(ADDR_WIDTH/LOW_DATA_WIDTH).
- FSM states:
  - IDLE: accept with data==CMD_WRITE -> ADDR; any other word -> stay IDLE, drop_count+1 (saturating at 255).
  - ADDR: the ADDR_WORDS accepted words fill base address little-endian (first word = bits [LOW-1:0]); excess bits truncated. After the last address word -> LEN.
  - LEN: accepted word[LEN_WIDTH-1:0] = number of payload low words L. L==0 -> IDLE, no beat emitted. L>0 -> DATA.
  - DATA: the k-th payload word (k from 0) goes to lane k mod RATIO.
    - A beat completes at lane RATIO-1 or at k==L-1.
    - On the last word -> IDLE.
- Low-side ready:
  - low_read_ready=1 in IDLE/ADDR/LEN.
  - In DATA, low_read_ready=0 only when the offered word would complete a beat while the output register holds a beat and high_write_ready=0.
- Beat output:
  - Completion on accept in cycle N -> high_write_valid=1 in cycle N+1.
  - high_write_addr = base + beat index, mod 2**ADDR_WIDTH (wraps).
  - Lane i = data[i*LOW+:LOW]. Unfilled lanes are 0 with strb bit 0; full beat strb all-ones.
  - high_write_last=1 on the final beat only.
- Output holding:
  - A beat holds stable until high_write_valid && high_write_ready.
  - Accept and drain in the same cycle -> the next beat loads with no bubble (full throughput at ready=1).
- Next frame: the header of the next frame is parsed while the final beat is still pending; its first payload beat stalls per the ready rule.
- Counters: the payload counter is LEN_WIDTH bits and never overflows, since k < L <= 2**LEN_WIDTH-1.
- Reset mid-frame: async clear of everything. A pending beat is lost and the partial frame discarded.

Decomposition:
- Shared package l2h_pkg:
  - state enum (IDLE, ADDR, LEN, DATA).
  - CMD_WRITE default.
  - function computing ADDR_WORDS.
- One sub-module, l2h_out_reg: single-entry valid/ready holding register for {addr, data, strb, last}; also provides the can-load signal used for low_read_ready.

Test Plan:
All scenarios use default parameters (LOW=8, RATIO=4, ADDR=16).
- Frame A5,10,00,08, then payload 01..08, ready=1 -> beat addr 0x0010 data 0x04030201 strb F last 0, next cycle addr 0x0011 data 0x08070605 strb F last 1.
- Same header with len 05, payload 01..05 -> second beat data 0x00000005 strb 0x1 last 1; len 00 -> no beat, state IDLE after LEN word.
- Scenario 1 with high_write_ready=0 for 6 cycles after the first beat appears -> first beat held stable, low_read_ready=0 while word 08 is offered, no data loss, beats then in order.
- Words 00, 3C, then a frame -> no output for 00/3C, drop_count=2, frame converted normally; 300 junk words -> drop_count=255.
- Frame A5,FF,FF,08, payload 01..08 -> beats at 0xFFFF then 0x0000.
- Assert rst_n low after the 3rd payload word -> all outputs 0 immediately. After release, a fresh scenario-1 frame produces the correct two beats.
